// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer slice.
// Contents: state encoding (HOLD/WAIT_LOCK/RELEASE/RUN), status widths,
// and the saturating lock-loss counter update used when
// RESET_SEQ_LOSS_COUNT_EN is defined.
package reset_seq_pkg;

  localparam int unsigned SEQ_STATE_W = 2;
  localparam int unsigned LOSS_CNT_W  = 8;

  typedef enum logic [SEQ_STATE_W-1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

  // Saturating increment; a clear landing with an increment yields 1.
  function automatic logic [LOSS_CNT_W-1:0] loss_cnt_next(
    input logic [LOSS_CNT_W-1:0] cnt,
    input logic                  inc,
    input logic                  clr
  );
    logic [LOSS_CNT_W-1:0] nxt;
    nxt = cnt;
    if (inc) begin
      if (clr)                    nxt = LOSS_CNT_W'(1);
      else if (cnt != LOSS_CNT_MAX) nxt = cnt + LOSS_CNT_W'(1);
    end else if (clr) begin
      nxt = '0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and its surroundings.
// Inputs : ext_rst_n_async, pll_locked[NUM_PLLS], sw_rst_req, lock_lost_clr
// Outputs: rst_n_domains[NUM_DOMAINS], rst_n_output, seq_state[2], lock_lost,
//          lock_loss_count[8] (only with RESET_SEQ_LOSS_COUNT_EN defined)
// master = environment side, slave = sequencer side.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_PLLS    = 2,
  parameter int unsigned NUM_DOMAINS = 5
);

  logic                   ext_rst_n_async;
  logic [NUM_PLLS-1:0]    pll_locked;
  logic                   sw_rst_req;
  logic                   lock_lost_clr;
  logic [NUM_DOMAINS-1:0] rst_n_domains;
  logic                   rst_n_output;
  logic [SEQ_STATE_W-1:0] seq_state;
  logic                   lock_lost;
`ifdef RESET_SEQ_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0]  lock_loss_count;
`endif

  modport master (
    output ext_rst_n_async,
    output pll_locked,
    output sw_rst_req,
    output lock_lost_clr,
    input  rst_n_domains,
    input  rst_n_output,
    input  seq_state,
`ifdef RESET_SEQ_LOSS_COUNT_EN
    input  lock_loss_count,
`endif
    input  lock_lost
  );

  modport slave (
    input  ext_rst_n_async,
    input  pll_locked,
    input  sw_rst_req,
    input  lock_lost_clr,
    output rst_n_domains,
    output rst_n_output,
    output seq_state,
`ifdef RESET_SEQ_LOSS_COUNT_EN
    output lock_loss_count,
`endif
    output lock_lost
  );

endinterface

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for asynchronous level inputs.
// Ports: clk_input, rst_n_input (sync, active-low, clears every stage),
//        d[WIDTH] async input, q[WIDTH] synchronised output (STAGES flops late).
module sync_chain #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_input,
  input  logic             rst_n_input,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift register; stage 0 is the metastability-catching flop.
  always_ff @(posedge clk_input) begin
    if (!rst_n_input) begin
      for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: supervises the reset button and PLL locks, then
// releases NUM_DOMAINS active-low domain resets one at a time,
// STAGGER_CYCLES apart, before raising rst_n_output in RUN.
// Ports: clk_input, rst_n_input (sync, active-low), bus (reset_sequencer_if.slave,
//        whose NUM_PLLS/NUM_DOMAINS must match this module's parameters).
// Optional: RESET_SEQ_LOSS_COUNT_EN adds bus.lock_loss_count, a saturating
//           count of lock-loss aborts.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_PLLS       = 2,
  parameter int unsigned NUM_DOMAINS    = 5,
  parameter int unsigned SYNC_STAGES    = 4,
  parameter int unsigned HOLD_CYCLES    = 500000,
  parameter int unsigned LOCK_FILTER    = 64,
  parameter int unsigned STAGGER_CYCLES = 16
) (
  input  logic                 clk_input,
  input  logic                 rst_n_input,
  reset_sequencer_if.slave     bus
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_FILTER + 1);
  localparam int unsigned STG_W  = $clog2(STAGGER_CYCLES + 1);
  localparam int unsigned IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILTER - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  logic                   ext_ok;
  logic [NUM_PLLS-1:0]    locks_sync;
  logic                   all_locked;

  seq_state_e             state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [LOCK_W-1:0]      lock_q, lock_d;
  logic [STG_W-1:0]       stg_q, stg_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   run_q, run_d;
  logic                   lost_q, lost_d;
  logic                   loss_set;
`ifdef RESET_SEQ_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0]  cnt_q, cnt_d;
`endif

  // Input synchronisers
  sync_chain #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_ext_sync (
    .clk_input   (clk_input),
    .rst_n_input (rst_n_input),
    .d           (bus.ext_rst_n_async),
    .q           (ext_ok)
  );

  sync_chain #(.WIDTH(NUM_PLLS), .STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_input   (clk_input),
    .rst_n_input (rst_n_input),
    .d           (bus.pll_locked),
    .q           (locks_sync)
  );

  assign all_locked = &locks_sync;

  // Next-state, counters and registered-output next values
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    lock_d   = lock_q;
    stg_d    = stg_q;
    idx_d    = idx_q;
    dom_d    = dom_q;
    loss_set = 1'b0;

    if (!ext_ok) begin
      state_d = HOLD;
      hold_d  = '0;
      lock_d  = '0;
      stg_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
    end else if (!all_locked && (state_q == RELEASE || state_q == RUN)) begin
      state_d  = WAIT_LOCK;
      hold_d   = '0;
      lock_d   = '0;
      stg_d    = '0;
      idx_d    = '0;
      dom_d    = '0;
      loss_set = 1'b1;
    end else if (bus.sw_rst_req && state_q != HOLD) begin
      state_d = HOLD;
      hold_d  = '0;
      lock_d  = '0;
      stg_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = WAIT_LOCK;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (!all_locked) begin
            lock_d = '0;
          end else if (lock_q == LOCK_LAST) begin
            // Domain 0 is already released in the first RELEASE cycle so
            // every later domain lands a full stagger after its predecessor.
            state_d  = RELEASE;
            lock_d   = '0;
            stg_d    = '0;
            idx_d    = '0;
            dom_d[0] = 1'b1;
          end else begin
            lock_d = lock_q + LOCK_W'(1);
          end
        end
        RELEASE: begin
          if (stg_q == STG_LAST) begin
            stg_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
            end else begin
              idx_d        = idx_q + IDX_W'(1);
              dom_d[idx_d] = 1'b1;
            end
          end else begin
            stg_d = stg_q + STG_W'(1);
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end

    run_d  = (state_d == RUN);
    // Set wins over a coincident clear.
    lost_d = loss_set | (lost_q & ~bus.lock_lost_clr);
  end

`ifdef RESET_SEQ_LOSS_COUNT_EN
  assign cnt_d = loss_cnt_next(cnt_q, loss_set, bus.lock_lost_clr);
`endif

  // State and output registers
  always_ff @(posedge clk_input) begin
    if (!rst_n_input) begin
      state_q <= HOLD;
      hold_q  <= '0;
      lock_q  <= '0;
      stg_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      run_q   <= 1'b0;
      lost_q  <= 1'b0;
`ifdef RESET_SEQ_LOSS_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      lock_q  <= lock_d;
      stg_q   <= stg_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      run_q   <= run_d;
      lost_q  <= lost_d;
`ifdef RESET_SEQ_LOSS_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.rst_n_domains = dom_q;
  assign bus.rst_n_output  = run_q;
  assign bus.seq_state     = state_q;
  assign bus.lock_lost     = lost_q;
`ifdef RESET_SEQ_LOSS_COUNT_EN
  assign bus.lock_loss_count = cnt_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus a
// randomized phase, compared every cycle against a phase/elapsed-time model.
module tb_reset_sequencer;

  localparam int NP = 2;
  localparam int ND = 3;
  localparam int SS = 2;
  localparam int HC = 10;
  localparam int LF = 4;
  localparam int ST = 3;

  localparam int M_HOLD = 0;
  localparam int M_WAIT = 1;
  localparam int M_REL  = 2;
  localparam int M_RUN  = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_PLLS(NP), .NUM_DOMAINS(ND)) bus ();

  reset_sequencer #(
    .NUM_PLLS       (NP),
    .NUM_DOMAINS    (ND),
    .SYNC_STAGES    (SS),
    .HOLD_CYCLES    (HC),
    .LOCK_FILTER    (LF),
    .STAGGER_CYCLES (ST)
  ) dut (
    .clk_input   (clk),
    .rst_n_input (rst_n),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: current phase, cycles elapsed in it, input sync pipelines.
  int          m_st   = M_HOLD;
  int          m_t    = 0;
  bit [SS-1:0] e_pipe = '0;
  bit [SS-1:0] l_pipe = '0;
  bit          m_lost = 1'b0;
  int          m_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int exp_domains();
    int n;
    if (m_st == M_RUN) return (1 << ND) - 1;
    if (m_st != M_REL) return 0;
    n = 1 + m_t / ST;
    if (n > ND) n = ND;
    return (1 << n) - 1;
  endfunction

  task automatic model_edge();
    bit ok, lk, set;
    set = 1'b0;
    if (!rst_n) begin
      m_st = M_HOLD; m_t = 0; m_lost = 1'b0; m_cnt = 0;
      e_pipe = '0; l_pipe = '0;
      return;
    end
    ok = e_pipe[SS-1];
    lk = l_pipe[SS-1];
    if (!ok) begin
      m_st = M_HOLD; m_t = 0;
    end else if (!lk && (m_st == M_REL || m_st == M_RUN)) begin
      m_st = M_WAIT; m_t = 0; set = 1'b1;
    end else if (bus.sw_rst_req && m_st != M_HOLD) begin
      m_st = M_HOLD; m_t = 0;
    end else begin
      case (m_st)
        M_HOLD: if (m_t == HC - 1) begin m_st = M_WAIT; m_t = 0; end else m_t++;
        M_WAIT: if (!lk) m_t = 0;
                else if (m_t == LF - 1) begin m_st = M_REL; m_t = 0; end
                else m_t++;
        M_REL:  if (m_t == ND * ST - 1) begin m_st = M_RUN; m_t = 0; end else m_t++;
        default: ;
      endcase
    end
    m_lost = set | (m_lost & !bus.lock_lost_clr);
    if (set) m_cnt = bus.lock_lost_clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
    else if (bus.lock_lost_clr) m_cnt = 0;
    e_pipe = {e_pipe[SS-2:0], bus.ext_rst_n_async};
    l_pipe = {l_pipe[SS-2:0], &bus.pll_locked};
  endtask

  task automatic compare_all();
    check("seq_state",     32'(bus.seq_state),     32'(m_st));
    check("rst_n_domains", 32'(bus.rst_n_domains), 32'(exp_domains()));
    check("rst_n_output",  32'(bus.rst_n_output),  32'(m_st == M_RUN));
    check("lock_lost",     32'(bus.lock_lost),     32'(m_lost));
`ifdef RESET_SEQ_LOSS_COUNT_EN
    check("lock_loss_count", 32'(bus.lock_loss_count), 32'(m_cnt));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Advance until the model reaches phase st (and elapsed t, unless t<0).
  task automatic wait_model(input int st, input int t, input int budget);
    int k = 0;
    while (!(m_st == st && (t < 0 || m_t == t)) && k < budget) begin
      cycle();
      k++;
    end
    if (k >= budget) check("wait_budget", 32'(bus.seq_state), 32'(st));
  endtask

  initial begin
    int n, k;
    int t_wait, t_rel, t_d0, t_d1, t_d2, t_run;

    rst_n = 1'b0;
    bus.ext_rst_n_async = 1'b1;
    bus.pll_locked      = '1;
    bus.sw_rst_req      = 1'b0;
    bus.lock_lost_clr   = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;

    // Clean power-up: measure phase timing from reset release
    t_wait = -1; t_rel = -1; t_d0 = -1; t_d1 = -1; t_d2 = -1; t_run = -1;
    for (n = 1; n <= 60; n++) begin
      cycle();
      if (t_wait < 0 && bus.seq_state == 2'd1)       t_wait = n;
      if (t_rel  < 0 && bus.seq_state == 2'd2)       t_rel  = n;
      if (t_d0   < 0 && bus.rst_n_domains == 3'b001) t_d0   = n;
      if (t_d1   < 0 && bus.rst_n_domains == 3'b011) t_d1   = n;
      if (t_d2   < 0 && bus.rst_n_domains == 3'b111) t_d2   = n;
      if (t_run  < 0 && bus.rst_n_output == 1'b1)    t_run  = n;
    end
    check("pwrup_hold_len", 32'(t_wait),        32'(SS + HC));
    check("pwrup_lock_len", 32'(t_rel - t_wait), 32'(LF));
    check("pwrup_d0_at_rel", 32'(t_d0 - t_rel),  32'(0));
    check("pwrup_d0_d1",    32'(t_d1 - t_d0),    32'(ST));
    check("pwrup_d1_d2",    32'(t_d2 - t_d1),    32'(ST));
    check("pwrup_d2_run",   32'(t_run - t_d2),   32'(ST));

    // Button glitch landing at hold count 7
    bus.sw_rst_req = 1'b1; cycle(); bus.sw_rst_req = 1'b0;
    wait_model(M_HOLD, 7 - SS, 50);
    bus.ext_rst_n_async = 1'b0; cycle(); bus.ext_rst_n_async = 1'b1;
    k = 1;
    while (bus.seq_state != 2'd1 && k < 40) begin cycle(); k++; end
    check("glitch_to_wait", 32'(k), 32'(SS + HC + 1));

    // Lock loss in RUN
    wait_model(M_RUN, -1, 100);
    bus.pll_locked = 2'b01; cycle(); bus.pll_locked = 2'b11;
    repeat (SS) cycle();
    check("run_loss_domains", 32'(bus.rst_n_domains), 32'(0));
    check("run_loss_state",   32'(bus.seq_state),     32'(1));
    check("run_loss_flag",    32'(bus.lock_lost),     32'(1));
    wait_model(M_RUN, -1, 100);

    // Lock loss after domain 1 released
    bus.sw_rst_req = 1'b1; cycle(); bus.sw_rst_req = 1'b0;
    wait_model(M_REL, ST, 100);
    check("mid_rel_d1", 32'(bus.rst_n_domains), 32'(3'b011));
    bus.pll_locked = 2'b10; cycle(); bus.pll_locked = 2'b11;
    repeat (SS) cycle();
    check("mid_rel_domains", 32'(bus.rst_n_domains), 32'(0));
    check("mid_rel_state",   32'(bus.seq_state),     32'(1));

    // Simultaneous ext low, lock loss and sw reset
    wait_model(M_RUN, -1, 100);
    bus.ext_rst_n_async = 1'b0; bus.pll_locked = 2'b00; cycle();
    bus.ext_rst_n_async = 1'b1; bus.pll_locked = 2'b11;
    repeat (SS - 1) cycle();
    bus.sw_rst_req = 1'b1; cycle(); bus.sw_rst_req = 1'b0;
    check("simul_state", 32'(bus.seq_state), 32'(0));
    check("simul_lost",  32'(bus.lock_lost), 32'(1));

    // Clear then a clear coinciding with a new loss
    bus.lock_lost_clr = 1'b1; cycle(); bus.lock_lost_clr = 1'b0;
    check("clr_lost", 32'(bus.lock_lost), 32'(0));
    wait_model(M_RUN, -1, 100);
    bus.pll_locked = 2'b01; cycle(); bus.pll_locked = 2'b11;
    repeat (SS - 1) cycle();
    bus.lock_lost_clr = 1'b1; cycle(); bus.lock_lost_clr = 1'b0;
    check("set_wins_lost",  32'(bus.lock_lost), 32'(1));
    check("set_wins_state", 32'(bus.seq_state), 32'(1));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n               = ($urandom_range(0, 999) != 0);
      bus.ext_rst_n_async = ($urandom_range(0, 199) != 0);
      for (int b = 0; b < NP; b++) bus.pll_locked[b] = ($urandom_range(0, 79) != 0);
      bus.sw_rst_req      = ($urandom_range(0, 149) == 0);
      bus.lock_lost_clr   = ($urandom_range(0, 39) == 0);
      cycle();
    end
    rst_n = 1'b1; bus.ext_rst_n_async = 1'b1; bus.pll_locked = '1;
    bus.sw_rst_req = 1'b0; bus.lock_lost_clr = 1'b0;

`ifdef RESET_SEQ_LOSS_COUNT_EN
    // Saturation of the lock-loss counter
    bus.lock_lost_clr = 1'b1; cycle(); bus.lock_lost_clr = 1'b0;
    for (int e = 0; e < 300; e++) begin
      wait_model(M_REL, -1, 200);
      bus.pll_locked = 2'b10; cycle(); bus.pll_locked = 2'b11;
    end
    repeat (SS + 1) cycle();
    check("loss_cnt_sat", 32'(bus.lock_loss_count), 32'(255));
    bus.lock_lost_clr = 1'b1; cycle(); bus.lock_lost_clr = 1'b0;
    check("loss_cnt_clr", 32'(bus.lock_loss_count), 32'(0));
`endif

    repeat (5) cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
